// File: rtl/udp_pkg.sv
// udp_pkg: constants shared by the UDP TX framing logic
package udp_pkg;
  localparam int UDP_MAX_PAYLOAD_WORDS = 368;
  localparam int AXIS_DATA_W = 32;
endpackage

// File: rtl/udp_tx_packetizer_if.sv
// udp_tx_packetizer_if: AXI-Stream word channel (tdata/tvalid/tlast/tready)
//   master: drives tdata, tvalid, tlast; receives tready
//   slave:  receives tdata, tvalid, tlast; drives tready
interface udp_tx_packetizer_if import udp_pkg::*; ();
  logic [AXIS_DATA_W-1:0] tdata;
  logic                   tvalid;
  logic                   tlast;
  logic                   tready;
  modport master(output tdata, tvalid, tlast, input tready);
  modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/udp_tx_packetizer.sv
// udp_tx_packetizer: frames a 32-bit AXI-Stream payload into UDP datagrams
//   aclk, aresetn : clock, asynchronous active-low reset
//   s_axis        : payload in (tlast forces a datagram boundary)
//   m_axis        : framed words out, tlast on each datagram's final word
//   flush         : pulse that closes the currently held open word
//   pkt_count     : datagrams emitted, modulo 2^16
module udp_tx_packetizer import udp_pkg::*; #(
  parameter int MAX_WORDS      = 256,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  udp_tx_packetizer_if.slave         s_axis,
  udp_tx_packetizer_if.master        m_axis,
  input  logic                       flush,
  output logic [15:0]                pkt_count
);
  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] C_MAX = CW'(MAX_WORDS);
  localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT_CYCLES - 1);
  if (MAX_WORDS < 1 || MAX_WORDS > UDP_MAX_PAYLOAD_WORDS || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("udp_tx_packetizer: MAX_WORDS must be 1..%0d and TIMEOUT_CYCLES >= 1", UDP_MAX_PAYLOAD_WORDS);
  end
  logic                   r_h_valid;
  logic                   r_h_closed;
  logic [AXIS_DATA_W-1:0] r_h_data;
  logic [CW-1:0]          r_word_cnt;
  logic [TW-1:0]          r_timer;
  logic                   r_m_tvalid;
  logic                   r_m_tlast;
  logic [AXIS_DATA_W-1:0] r_m_tdata;
  logic [15:0]            r_pkt_count;
  logic                   w_o_free;
  logic                   w_acc;
  logic                   w_h_open;
  logic                   w_flush;
  logic                   w_expire;
  logic                   w_tlast;
  logic                   w_xfer;
  logic [CW-1:0]          w_cnt_next;
  logic                   w_close_new;
  assign w_o_free       = !r_m_tvalid || m_axis.tready;
  assign s_axis.tready  = aresetn && (!r_h_valid || w_o_free);
  assign w_acc          = s_axis.tvalid && s_axis.tready;
  assign w_h_open       = r_h_valid && !r_h_closed;
  assign w_flush        = w_h_open && flush;
  // an accept in the same cycle pre-empts the timeout, so expiry only counts idle cycles
  assign w_expire       = w_h_open && !w_acc && r_timer == T_LIM;
  // flush wins over a simultaneous accept for the outgoing word's tlast
  assign w_tlast        = r_h_closed || w_flush || w_expire;
  assign w_xfer         = w_o_free && r_h_valid && (w_tlast || w_acc);
  // a flushed old word ends its packet, so the incoming word counts from zero
  assign w_cnt_next     = (w_flush ? '0 : r_word_cnt) + CW'(1);
  assign w_close_new    = w_cnt_next == C_MAX || s_axis.tlast;
  assign m_axis.tdata   = r_m_tdata;
  assign m_axis.tvalid  = r_m_tvalid;
  assign m_axis.tlast   = r_m_tlast;
  assign pkt_count      = r_pkt_count;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_h_valid   <= 1'b0;
      r_h_closed  <= 1'b0;
      r_h_data    <= '0;
      r_word_cnt  <= '0;
      r_timer     <= '0;
      r_m_tvalid  <= 1'b0;
      r_m_tlast   <= 1'b0;
      r_m_tdata   <= '0;
      r_pkt_count <= '0;
    end else begin
      if (w_acc) begin
        r_h_valid  <= 1'b1;
        r_h_data   <= s_axis.tdata;
        r_h_closed <= w_close_new;
      end else if (w_xfer) begin
        r_h_valid  <= 1'b0;
        r_h_closed <= 1'b0;
      end else if (w_flush || w_expire) begin
        // output busy: mark the word closed so it leaves with tlast once O frees up
        r_h_closed <= 1'b1;
      end
      if (w_acc)
        r_word_cnt <= w_close_new ? '0 : w_cnt_next;
      else if (w_flush || w_expire)
        r_word_cnt <= '0;
      r_timer <= (w_h_open && !w_acc && !w_expire && !w_flush) ? r_timer + TW'(1) : '0;
      if (w_xfer) begin
        r_m_tvalid <= 1'b1;
        r_m_tdata  <= r_h_data;
        r_m_tlast  <= w_tlast;
      end else if (m_axis.tready) begin
        r_m_tvalid <= 1'b0;
      end
      if (r_m_tvalid && m_axis.tready && r_m_tlast)
        r_pkt_count <= r_pkt_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_udp_tx_packetizer.sv
// tb_udp_tx_packetizer: directed self-checking bench for udp_tx_packetizer
module tb_udp_tx_packetizer;
  logic        aclk;
  logic        aresetn;
  logic        flush;
  logic        en1;
  logic [15:0] pkt_count;
  logic [15:0] pkt1;
  int          tests;
  int          fails;
  int          cyc;
  int          c0;
  logic [32:0] obs[$];
  int          obs_cyc[$];
  logic [32:0] exp_q[$];
  udp_tx_packetizer_if s_if();
  udp_tx_packetizer_if m_if();
  udp_tx_packetizer_if s1_if();
  udp_tx_packetizer_if m1_if();
  udp_tx_packetizer #(.MAX_WORDS(4), .TIMEOUT_CYCLES(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .s_axis(s_if.slave), .m_axis(m_if.master),
    .flush(flush), .pkt_count(pkt_count));
  udp_tx_packetizer #(.MAX_WORDS(1), .TIMEOUT_CYCLES(16)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .s_axis(s1_if.slave), .m_axis(m1_if.master),
    .flush(1'b0), .pkt_count(pkt1));
  assign s1_if.tdata  = s_if.tdata;
  assign s1_if.tvalid = s_if.tvalid && en1;
  assign s1_if.tlast  = s_if.tlast;
  assign m1_if.tready = 1'b1;
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  initial cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;
  always @(negedge aclk)
    if (m_if.tvalid && m_if.tready) begin
      obs.push_back({m_if.tlast, m_if.tdata});
      obs_cyc.push_back(cyc);
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask
  task automatic step();
    @(posedge aclk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) step();
  endtask
  task automatic push(input logic [31:0] d, input logic l, input logic f);
    bit ok;
    ok = 1'b0;
    s_if.tdata = d;
    s_if.tvalid = 1'b1;
    s_if.tlast = l;
    flush = f;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge aclk);
      ok = s_if.tready;
      if (!ok) step();
    end
    if (ok) step();
    else check("push_stall", 32'(ok), 1);
    s_if.tvalid = 1'b0;
    s_if.tlast = 1'b0;
    flush = 1'b0;
  endtask
  task automatic ex(input logic [31:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask
  task automatic verify(input string tag);
    check({tag, "_n"}, 32'(obs.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_d%0d", tag, i), i < obs.size() ? obs[i][31:0] : 32'hDEADBEEF, exp_q[i][31:0]);
      check($sformatf("%s_l%0d", tag, i), i < obs.size() ? 32'(obs[i][32]) : 32'hBAD, 32'(exp_q[i][32]));
    end
    obs.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask
  initial begin
    tests = 0;
    fails = 0;
    aresetn = 1'b0;
    flush = 1'b0;
    en1 = 1'b1;
    s_if.tdata = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast = 1'b0;
    m_if.tready = 1'b1;
    idle(2);
    @(negedge aclk);
    check("rst_s_tready", 32'(s_if.tready), 0);
    check("rst_m_tvalid", 32'(m_if.tvalid), 0);
    check("rst_pkt", 32'(pkt_count), 0);
    step();
    aresetn = 1'b1;
    @(negedge aclk);
    check("rel_s_tready", 32'(s_if.tready), 1);
    step();
    // back-to-back 8 words, MAX_WORDS=4
    for (int i = 1; i <= 8; i++) push(32'(i), 1'b0, 1'b0);
    idle(4);
    check("b2b_rate", obs.size() > 7 ? 32'(obs_cyc[7] - obs_cyc[0]) : 0, 7);
    check("b2b_pkt", 32'(pkt_count), 2);
    check("max1_pkt", 32'(pkt1), 8);
    for (int i = 1; i <= 8; i++) ex(32'(i), i == 4 || i == 8);
    verify("b2b");
    en1 = 1'b0;
    // idle timeout after 3 words
    push(32'h11, 1'b0, 1'b0);
    push(32'h12, 1'b0, 1'b0);
    push(32'h13, 1'b0, 1'b0);
    c0 = cyc;
    idle(20);
    check("to_lat", obs.size() > 2 ? 32'(obs_cyc[2] - c0) : 0, 16);
    check("to_pkt", 32'(pkt_count), 3);
    ex(32'h11, 0); ex(32'h12, 0); ex(32'h13, 1);
    verify("to");
    // source tlast on word 2, then a full 4-word packet
    push(32'h21, 1'b0, 1'b0);
    push(32'h22, 1'b1, 1'b0);
    for (int i = 3; i <= 6; i++) push(32'h20 + 32'(i), 1'b0, 1'b0);
    idle(4);
    check("sl_pkt", 32'(pkt_count), 5);
    ex(32'h21, 0); ex(32'h22, 1); ex(32'h23, 0); ex(32'h24, 0); ex(32'h25, 0); ex(32'h26, 1);
    verify("sl");
    // backpressure
    m_if.tready = 1'b0;
    push(32'h31, 1'b0, 1'b0);
    push(32'h32, 1'b0, 1'b0);
    s_if.tdata = 32'h33;
    s_if.tvalid = 1'b1;
    @(negedge aclk);
    check("bp_stall", 32'(s_if.tready), 0);
    idle(9);
    m_if.tready = 1'b1;
    @(negedge aclk);
    check("bp_release", 32'(s_if.tready), 1);
    step();
    s_if.tvalid = 1'b0;
    push(32'h34, 1'b0, 1'b0);
    idle(4);
    check("bp_pkt", 32'(pkt_count), 6);
    ex(32'h31, 0); ex(32'h32, 0); ex(32'h33, 0); ex(32'h34, 1);
    verify("bp");
    // flush with accept, standalone flush, flush on empty H
    push(32'hA, 1'b0, 1'b0);
    idle(2);
    push(32'hB, 1'b0, 1'b1);
    push(32'hC, 1'b0, 1'b0);
    push(32'hD, 1'b0, 1'b0);
    push(32'hE, 1'b0, 1'b0);
    idle(3);
    push(32'hF0, 1'b0, 1'b0);
    idle(2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle(3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle(3);
    check("fl_pkt", 32'(pkt_count), 9);
    ex(32'hA, 1); ex(32'hB, 0); ex(32'hC, 0); ex(32'hD, 0); ex(32'hE, 1); ex(32'hF0, 1);
    verify("fl");
    // reset mid-packet
    push(32'h51, 1'b0, 1'b0);
    push(32'h52, 1'b0, 1'b0);
    aresetn = 1'b0;
    #1;
    check("mid_rst_tvalid", 32'(m_if.tvalid), 0);
    check("mid_rst_tdata", m_if.tdata, 0);
    check("mid_rst_tlast", 32'(m_if.tlast), 0);
    check("mid_rst_pkt", 32'(pkt_count), 0);
    check("mid_rst_s_tready", 32'(s_if.tready), 0);
    idle(3);
    aresetn = 1'b1;
    @(negedge aclk);
    check("mid_rel_s_tready", 32'(s_if.tready), 1);
    step();
    obs.delete();
    obs_cyc.delete();
    for (int i = 1; i <= 4; i++) push(32'h60 + 32'(i), 1'b0, 1'b0);
    idle(4);
    check("rs_pkt", 32'(pkt_count), 1);
    ex(32'h61, 0); ex(32'h62, 0); ex(32'h63, 0); ex(32'h64, 1);
    verify("rs");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/udp_tx_packetizer.md
# udp_tx_packetizer

Frames a continuous 32-bit AXI-Stream payload into UDP-sized datagrams for the Ethernet/UDP/ARP core's TX stream input. Packet boundaries are set by word count, an idle timeout, a source `tlast` or an explicit flush. The block drives `tlast` on each datagram's final word. It sits in the `aclk` domain, directly upstream of the core's `s_axis_*` TX port.

## Interface
- `MAX_WORDS`, default 256: payload words per datagram. Legal range 1..368 (1472-byte UDP payload).
- `TIMEOUT_CYCLES`, default 1000: idle `aclk` cycles before an open packet is closed. Must be ≥ 1.
- `aclk`, input, 1: single clock for all logic.
- `aresetn`, input, 1: asynchronous, active-low reset.
- `s_axis_tdata`, input, 32: payload word.
- `s_axis_tvalid`, input, 1: payload valid.
- `s_axis_tlast`, input, 1: optional source boundary. Forces a close on this word.
- `s_axis_tready`, output, 1: payload accept.
- `flush`, input, 1: single-cycle pulse that closes the currently held open word.
- `m_axis_tdata`, output, 32: framed word to the TX core.
- `m_axis_tvalid`, output, 1: framed word valid.
- `m_axis_tlast`, output, 1: last word of the datagram.
- `m_axis_tready`, input, 1: TX core accept.
- `pkt_count`, output, 16: datagrams emitted, wraps modulo 2^16.

## Operation
- Two registers carry data:
  - Hold register H: `h_valid`, `h_data`, `h_closed`.
  - Output register O: the `m_axis_*` outputs.
- `o_free = !m_axis_tvalid || m_axis_tready`.
- `s_axis_tready = !h_valid || o_free`. This is a combinational path from `m_axis_tready`; it is intentional.
- Input accept (`s_axis_tvalid && s_axis_tready`):
  - The word is loaded into H and `word_cnt` increments.
  - The word is closed if `word_cnt+1 == MAX_WORDS` or `s_axis_tlast` is set. A closed word resets `word_cnt` to 0.
- H→O transfer happens only when `o_free` and one of the following holds:
  - H is closed: O gets `tlast=1`.
  - A new word is accepted in the same cycle: O gets `tlast=0`, and H takes the new word.
  - The idle timer expires: O gets `tlast=1` and `word_cnt` clears.
  - `flush` is high: O gets `tlast=1` and `word_cnt` clears.
- Idle timer:
  - Counts cycles while H holds an open word and no input is accepted.
  - Cleared on every accept and whenever H is empty or closed.
  - Expires when the count reaches `TIMEOUT_CYCLES-1`.
  - If expiry occurs while O is busy, the close stays pending until `o_free`.
- `pkt_count` increments on every `m_axis_tvalid && m_axis_tready && m_axis_tlast`.
- Boundary conditions:
  - Timeout and input accept in the same cycle: the input wins. H moves with `tlast=0` and the timer clears.
  - `flush` and input accept in the same cycle: `flush` applies to the old H word (`tlast=1`). The new word starts a new packet with `word_cnt=1`.
  - `flush` with H empty or already closed: no effect.
  - `MAX_WORDS=1`: every word carries `tlast=1`.
  - `word_cnt` width is `$clog2(MAX_WORDS+1)`. The idle timer width is `$clog2(TIMEOUT_CYCLES+1)`.
  - No word is ever dropped or duplicated. Order is preserved.

## Timing
- Reset state (asynchronous):
  - `m_axis_tvalid=0`, `m_axis_tlast=0`, `m_axis_tdata=0`, `pkt_count=0`.
  - `h_valid=0`, `word_cnt=0`, timer=0.
  - `s_axis_tready=0` while `aresetn` is low, and 1 on the first cycle after release.
- Closed word latency: accepted at edge t, visible on `m_axis` after edge t+1 if O is free.
- Open word latency: visible on `m_axis` after the edge at which the next word is accepted.
- Timeout word: visible on `m_axis` after the edge at which the timer reaches `TIMEOUT_CYCLES-1` idle cycles.
- Sustained throughput is 1 word/cycle while `m_axis_tready=1`.
- Backpressure:
  - With H and O both occupied and `m_axis_tready=0`, `s_axis_tready` deasserts in the same cycle.
  - `s_axis_tready` reasserts combinationally when `m_axis_tready` rises.
- Reset mid-packet discards H and O contents. The next accepted word starts a packet with `word_cnt=1`.

## Structure
- Shared package `udp_pkg`:
  - Constant `UDP_MAX_PAYLOAD_WORDS = 368`, used as the `MAX_WORDS` bound check.
  - Constant `AXIS_DATA_W = 32`.
- Single module; no sub-module. The idle timer and word counter are inline.
- An elaboration-time check rejects `MAX_WORDS` outside 1..368 and `TIMEOUT_CYCLES` < 1.

## Test plan
- `MAX_WORDS=4`, 8 back-to-back words 0x1..0x8, `m_axis_tready=1`:
  - `tlast` only on 0x4 and 0x8; `pkt_count=2`.
  - The output word stream equals the input stream.
- `TIMEOUT_CYCLES=16`, 3 words then idle:
  - 0x1 and 0x2 emerge with `tlast=0`.
  - 0x3 emerges with `tlast=1` after 16 idle cycles; `pkt_count=1`.
  - The next word starts a fresh count.
- `s_axis_tlast` on word 2 of a stream with `MAX_WORDS=4`:
  - Output `tlast` on word 2.
  - The following 4 words form the next packet, with `tlast` on its 4th word.
- `m_axis_tready` held low for 10 cycles mid-stream:
  - `s_axis_tready` drops once H and O are full.
  - After release, all words arrive once, in order, with no gaps or duplicates.
- `flush` with an open word 0xA, then `flush` in the same cycle as an accept of 0xB:
  - 0xA emerges with `tlast=1`.
  - 0xB begins a new packet with `word_cnt=1`.
- `aresetn` pulsed low mid-packet:
  - All outputs read 0 during reset, including `pkt_count`.
  - After release, a 4-word burst (`MAX_WORDS=4`) yields `tlast` on its 4th word.
